control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter: RA_REG, default 31, register index written by JAL.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instr[31:26] from instruction register; valid from DECODE onward.
REQ-005 funct  input  6  instr[5:0]; meaningful only when opcode=0.
REQ-006 mem_ready  input  1  memory handshake; 1 = access completes this cycle.
REQ-007 pc_we  output  1  PC register write enable (PC source chosen downstream from beq/bne/jump).
REQ-008 ir_we  output  1  instruction register write enable.
REQ-009 reg_we  output  1  register file write enable.
REQ-010 mem_we  output  1  data memory write enable.
REQ-011 beq, bne, jump  output  1 each  PC-select requests to the downstream PC chooser.
REQ-012 alu_op  output  2  ADD=0, SUB=1, XOR=2, SLT=3.
REQ-013 alu_src_b  output  2  0 rt, 1 sign-ext imm, 2 zero-ext imm.
REQ-014 reg_dst  output  2  0 rt, 1 rd, 2 RA_REG.
REQ-015 mem_to_reg  output  2  0 ALU result, 1 memory data, 2 PC+4.
REQ-016 instr_done  output  1  one-cycle pulse on final cycle of each instruction.
REQ-017 illegal  output  1  one-cycle pulse on unsupported opcode/funct.

Function
REQ-018 States: FETCH, DECODE, EXEC, MEM, WB; state register is the only sequential storage.
REQ-019 FETCH: ir_we=mem_ready, pc_we=mem_ready, beq=bne=jump=0; stay in FETCH while mem_ready=0, else go DECODE.
REQ-020 Supported: R-type ADD(0x20), SUB(0x22), SLT(0x2A); ADDI(0x08), XORI(0x0E), LW(0x23), SW(0x2B), BEQ(0x04), BNE(0x05), J(0x02), JAL(0x03).
REQ-021 R-type/ADDI/XORI: FETCH->DECODE->EXEC->WB->FETCH; WB asserts reg_we with reg_dst=1 (R) or 0 (imm), mem_to_reg=0.
REQ-022 ADDI uses alu_src_b=1, alu_op=ADD; XORI uses alu_src_b=2, alu_op=XOR; R-type alu_op from funct, alu_src_b=0.
REQ-023 LW: FETCH->DECODE->EXEC->MEM->WB (5 cycles with mem_ready=1); WB: reg_we=1, reg_dst=0, mem_to_reg=1.
REQ-024 SW: FETCH->DECODE->EXEC->MEM; MEM asserts mem_we=mem_ready.
REQ-025 MEM stalls while mem_ready=0; no enable other than mem_we gated by mem_ready is asserted during stall.
REQ-026 EXEC for LW/SW: alu_op=ADD, alu_src_b=1.
REQ-027 BEQ/BNE: FETCH->DECODE->EXEC->FETCH; EXEC asserts alu_op=SUB, alu_src_b=0, pc_we=1 and beq or bne=1.
REQ-028 J: DECODE asserts jump=1, pc_we=1, returns to FETCH (2 cycles).
REQ-029 JAL: as J plus reg_we=1, reg_dst=2, mem_to_reg=2 in the same DECODE cycle.
REQ-030 Unsupported opcode/funct: DECODE pulses illegal=1 and instr_done=1, asserts no write enable, returns to FETCH.
REQ-031 At most one of beq, bne, jump high in any cycle; all 0 outside REQ-027..029 cycles.
REQ-032 instr_done=1 exactly on the cycle the FSM transitions back to FETCH.
REQ-033 Outputs are combinational from state, opcode, funct, mem_ready; unused selects drive 0.

Reset
REQ-034 reset=1 at a rising edge forces state=FETCH, regardless of current state.
REQ-035 While reset=1 every enable and strobe (pc_we, ir_we, reg_we, mem_we, beq, bne, jump, instr_done, illegal) is 0.
REQ-036 Reset mid-instruction abandons it; no partial write occurs in the reset cycle; first post-reset cycle is FETCH.

Structure
REQ-037 Shared package holds state enum, opcode/funct constants, alu_op, alu_src_b, reg_dst, mem_to_reg encodings.
REQ-038 One sub-module, instr_decode: combinational opcode/funct -> instruction class and illegal flag.

Verification
REQ-039 Reset then LW (0x23), mem_ready=1 -> states F,D,E,M,W; reg_we=1,mem_to_reg=1 only in W; instr_done in W.
REQ-040 SW with mem_ready=0 for 3 MEM cycles -> stays MEM, mem_we=0 until mem_ready=1, then one mem_we pulse.
REQ-041 BNE (0x05) -> EXEC: pc_we=1,bne=1,beq=0,jump=0,alu_op=SUB; 3-cycle instruction.
REQ-042 JAL (0x03) -> DECODE: jump=1,pc_we=1,reg_we=1,reg_dst=2,mem_to_reg=2; next state FETCH.
REQ-043 opcode 0x3F -> illegal=1 in DECODE, all write enables 0, back to FETCH.
REQ-044 reset=1 during LW MEM -> that cycle all enables 0; next cycle FETCH with ir_we=mem_ready.

Source files
------------

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding,
// opcode/funct constants, datapath select encodings and the instruction
// class produced by instr_decode.
package control_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT} alu_op_t;
    typedef enum logic [1:0] {SRC_RT, SRC_SEXT, SRC_ZEXT} alu_src_t;
    typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} reg_dst_t;
    typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} mem_to_reg_t;

    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_SLT,
        C_ADDI, C_XORI,
        C_LW, C_SW,
        C_BEQ, C_BNE,
        C_J, C_JAL,
        C_ILLEGAL
    } iclass_t;

    function automatic logic is_rtype(input iclass_t c);
        return (c == C_ADD) || (c == C_SUB) || (c == C_SLT);
    endfunction

    // ALU operation for the three supported R-type functs.
    function automatic alu_op_t rtype_alu(input iclass_t c);
        case (c)
            C_SUB:   return ALU_SUB;
            C_SLT:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_fsm_instr_decode.sv
// instr_decode: purely combinational opcode/funct classifier.
//   opcode, funct : instruction fields (funct only meaningful for opcode 0)
//   cls           : instruction class
//   illegal       : 1 when the opcode/funct pair is not supported
module instr_decode
    import control_fsm_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    cls,
    output logic       illegal
);

    always_comb begin
        cls = C_ILLEGAL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  cls = C_ADD;
                    FN_SUB:  cls = C_SUB;
                    FN_SLT:  cls = C_SLT;
                    default: cls = C_ILLEGAL;
                endcase
            end
            OP_ADDI: cls = C_ADDI;
            OP_XORI: cls = C_XORI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            OP_BNE:  cls = C_BNE;
            OP_J:    cls = C_J;
            OP_JAL:  cls = C_JAL;
            default: cls = C_ILLEGAL;
        endcase
        illegal = (cls == C_ILLEGAL);
    end

endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle control unit (FETCH/DECODE/EXEC/MEM/WB).
//   clk, reset      : clock, synchronous active-high reset
//   opcode, funct   : instruction fields from the instruction register
//   mem_ready       : memory handshake, 1 = access completes this cycle
//   pc_we, ir_we, reg_we, mem_we : write enables
//   beq, bne, jump  : PC-select requests
//   alu_op, alu_src_b, reg_dst, mem_to_reg : datapath selects
//   instr_done      : pulse on the last cycle of each instruction
//   illegal         : pulse in DECODE for unsupported opcode/funct
// RA_REG is the link register index the downstream mux selects for reg_dst=2.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int unsigned RA_REG = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       reg_we,
    output logic       mem_we,
    output logic       beq,
    output logic       bne,
    output logic       jump,
    output logic [1:0] alu_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       instr_done,
    output logic       illegal
);

    if (RA_REG > 31) begin : g_ra_range
        $error("RA_REG must index a 32-entry register file");
    end

    state_t  state, state_nx;
    iclass_t cls;
    logic    dec_illegal;

    instr_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .cls     (cls),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        mem_we     = 1'b0;
        beq        = 1'b0;
        bne        = 1'b0;
        jump       = 1'b0;
        alu_op     = ALU_ADD;
        alu_src_b  = SRC_RT;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;

        // Reset overrides everything so nothing is written in the reset cycle.
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    ir_we = mem_ready;
                    pc_we = mem_ready;
                    if (mem_ready) state_nx = S_DECODE;
                end
                S_DECODE: begin
                    state_nx = S_EXEC;
                    if (dec_illegal) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        state_nx   = S_FETCH;
                    end else if (cls == C_J || cls == C_JAL) begin
                        jump       = 1'b1;
                        pc_we      = 1'b1;
                        instr_done = 1'b1;
                        state_nx   = S_FETCH;
                        if (cls == C_JAL) begin
                            reg_we     = 1'b1;
                            reg_dst    = DST_RA;
                            mem_to_reg = WB_PC4;
                        end
                    end
                end
                S_EXEC: begin
                    state_nx = S_WB;
                    case (cls)
                        C_ADDI: begin
                            alu_op    = ALU_ADD;
                            alu_src_b = SRC_SEXT;
                        end
                        C_XORI: begin
                            alu_op    = ALU_XOR;
                            alu_src_b = SRC_ZEXT;
                        end
                        C_LW, C_SW: begin
                            alu_op    = ALU_ADD;
                            alu_src_b = SRC_SEXT;
                            state_nx  = S_MEM;
                        end
                        C_BEQ, C_BNE: begin
                            alu_op     = ALU_SUB;
                            pc_we      = 1'b1;
                            beq        = (cls == C_BEQ);
                            bne        = (cls == C_BNE);
                            instr_done = 1'b1;
                            state_nx   = S_FETCH;
                        end
                        default: begin
                            if (is_rtype(cls)) alu_op = rtype_alu(cls);
                            else               state_nx = S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (cls == C_SW) begin
                        mem_we     = mem_ready;
                        instr_done = mem_ready;
                        if (mem_ready) state_nx = S_FETCH;
                    end else if (mem_ready) begin
                        state_nx = S_WB;
                    end
                end
                S_WB: begin
                    reg_we     = 1'b1;
                    instr_done = 1'b1;
                    state_nx   = S_FETCH;
                    if (is_rtype(cls)) reg_dst    = DST_RD;
                    if (cls == C_LW)   mem_to_reg = WB_MEM;
                end
                default: state_nx = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       mem_ready = 1'b0;
    logic       pc_we, ir_we, reg_we, mem_we, beq, bne, jump, instr_done, illegal;
    logic [1:0] alu_op, alu_src_b, reg_dst, mem_to_reg;

    control_fsm #(.RA_REG(31)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we),
        .mem_we(mem_we), .beq(beq), .bne(bne), .jump(jump), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_we, ir_we, reg_we, mem_we, beq, bne, jump, alu_op, alu_src_b, reg_dst, mem_to_reg, instr_done, illegal}
    logic [16:0] outs;
    assign outs = {pc_we, ir_we, reg_we, mem_we, beq, bne, jump,
                   alu_op, alu_src_b, reg_dst, mem_to_reg, instr_done, illegal};

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [16:0] o(input logic pc, ir, rw, mw, bq, bn, jp,
                                      input logic [1:0] aop, asrc, rdst, m2r,
                                      input logic dn, il);
        return {pc, ir, rw, mw, bq, bn, jp, aop, asrc, rdst, m2r, dn, il};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        mr;
        logic [16:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic r, input logic [5:0] op, fn, input logic mr,
                        input logic [16:0] exp, input string name);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.mr = mr; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [5:0] op, fn, input logic mr);
        @(negedge clk);
        reset = r; opcode = op; funct = fn; mem_ready = mr;
        #1;
    endtask

    task automatic check(input string name, input logic [16:0] exp);
        n_checks++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, outs, exp);
        end
    endtask

    // Reference model: each instruction is a numbered sequence of cycles
    // whose length depends on the instruction kind; outputs are listed per
    // (kind, cycle number) from the instruction behaviour table.
    localparam int K_ADD = 0, K_SUB = 1, K_SLT = 2, K_ADDI = 3, K_XORI = 4,
                   K_LW = 5, K_SW = 6, K_BEQ = 7, K_BNE = 8, K_J = 9,
                   K_JAL = 10, K_ILL = 11;

    function automatic int kind_of(input logic [5:0] op, fn);
        case (op)
            6'h00: return (fn == 6'h20) ? K_ADD : (fn == 6'h22) ? K_SUB :
                          (fn == 6'h2A) ? K_SLT : K_ILL;
            6'h08: return K_ADDI;
            6'h0E: return K_XORI;
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [16:0] ref_out(input logic rst, input logic [5:0] op, fn,
                                            input int cyc, input logic mr);
        int k = kind_of(op, fn);
        logic [16:0] r = '0;
        if (rst) return '0;
        case (cyc)
            0: r = o(mr, mr, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0);
            1: begin
                if (k == K_J)   r = o(1, 0, 0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0);
                if (k == K_JAL) r = o(1, 0, 1, 0, 0, 0, 1, 2'd0, 2'd0, 2'd2, 2'd2, 1, 0);
                if (k == K_ILL) r = o(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 1);
            end
            2: begin
                case (k)
                    K_SUB:      r = o(0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 0, 0);
                    K_SLT:      r = o(0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, 2'd0, 2'd0, 0, 0);
                    K_ADDI, K_LW, K_SW:
                                r = o(0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd0, 0, 0);
                    K_XORI:     r = o(0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2, 2'd0, 2'd0, 0, 0);
                    K_BEQ:      r = o(1, 0, 0, 0, 1, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 1, 0);
                    K_BNE:      r = o(1, 0, 0, 0, 0, 1, 0, 2'd1, 2'd0, 2'd0, 2'd0, 1, 0);
                    default:    r = '0;
                endcase
            end
            3: begin
                if (k == K_SW) r = o(0, 0, 0, mr, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, mr, 0);
                if (k <= K_SLT) r = o(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd1, 2'd0, 1, 0);
                if (k == K_ADDI || k == K_XORI)
                    r = o(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0);
            end
            4: if (k == K_LW) r = o(0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd1, 1, 0);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int ref_next(input logic rst, input logic [5:0] op, fn,
                                    input int cyc, input logic mr, input logic [16:0] exp);
        int k = kind_of(op, fn);
        if (rst || exp[1]) return 0;
        if (!mr && (cyc == 0 || (cyc == 3 && (k == K_LW || k == K_SW)))) return cyc;
        return cyc + 1;
    endfunction

    localparam logic [16:0] Z   = 17'd0;
    localparam logic [16:0] FCH = 17'b11000000000000000;

    initial begin
        logic [5:0] op_pool [12] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h23,
                                     6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        logic [5:0] fn_pool [4]  = '{6'h20, 6'h22, 6'h2A, 6'h21};
        int cyc;
        logic [5:0] rop, rfn;
        logic rr, rmr;
        logic [16:0] e;

        addv(1, 6'h23, 0, 1, Z, "reset");
        addv(0, 6'h23, 0, 1, FCH, "lw_fetch");
        addv(0, 6'h23, 0, 1, Z, "lw_decode");
        addv(0, 6'h23, 0, 1, o(0,0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,0,0), "lw_exec");
        addv(0, 6'h23, 0, 1, Z, "lw_mem");
        addv(0, 6'h23, 0, 1, o(0,0,1,0,0,0,0,2'd0,2'd0,2'd0,2'd1,1,0), "lw_wb");
        addv(0, 6'h05, 0, 1, FCH, "bne_fetch");
        addv(0, 6'h05, 0, 1, Z, "bne_decode");
        addv(0, 6'h05, 0, 1, o(1,0,0,0,0,1,0,2'd1,2'd0,2'd0,2'd0,1,0), "bne_exec");
        addv(0, 6'h03, 0, 1, FCH, "jal_fetch");
        addv(0, 6'h03, 0, 1, o(1,0,1,0,0,0,1,2'd0,2'd0,2'd2,2'd2,1,0), "jal_decode");
        addv(0, 6'h3F, 0, 1, FCH, "ill_fetch");
        addv(0, 6'h3F, 0, 1, o(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,1), "ill_decode");
        addv(0, 6'h2B, 0, 0, Z, "sw_fetch_stall");
        addv(0, 6'h2B, 0, 1, FCH, "sw_fetch");
        addv(0, 6'h2B, 0, 1, Z, "sw_decode");
        addv(0, 6'h2B, 0, 1, o(0,0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,0,0), "sw_exec");
        addv(0, 6'h2B, 0, 0, Z, "sw_mem_stall1");
        addv(0, 6'h2B, 0, 0, Z, "sw_mem_stall2");
        addv(0, 6'h2B, 0, 0, Z, "sw_mem_stall3");
        addv(0, 6'h2B, 0, 1, o(0,0,0,1,0,0,0,2'd0,2'd0,2'd0,2'd0,1,0), "sw_mem_done");
        addv(0, 6'h00, 6'h20, 1, FCH, "add_fetch");
        addv(0, 6'h00, 6'h20, 1, Z, "add_decode");
        addv(0, 6'h00, 6'h20, 1, Z, "add_exec");
        addv(0, 6'h00, 6'h20, 1, o(0,0,1,0,0,0,0,2'd0,2'd0,2'd1,2'd0,1,0), "add_wb");
        addv(0, 6'h0E, 0, 1, FCH, "xori_fetch");
        addv(0, 6'h0E, 0, 1, Z, "xori_decode");
        addv(0, 6'h0E, 0, 1, o(0,0,0,0,0,0,0,2'd2,2'd2,2'd0,2'd0,0,0), "xori_exec");
        addv(0, 6'h0E, 0, 1, o(0,0,1,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,0), "xori_wb");
        addv(0, 6'h00, 6'h21, 1, FCH, "badfn_fetch");
        addv(0, 6'h00, 6'h21, 1, o(0,0,0,0,0,0,0,2'd0,2'd0,2'd0,2'd0,1,1), "badfn_decode");

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].op, tbl[i].fn, tbl[i].mr);
            check(tbl[i].name, tbl[i].exp);
        end

        // Reset arriving in the MEM cycle of a load.
        drive(0, 6'h23, 0, 1); check("rst_lw_fetch", FCH);
        drive(0, 6'h23, 0, 1); check("rst_lw_decode", Z);
        drive(0, 6'h23, 0, 1); check("rst_lw_exec", o(0,0,0,0,0,0,0,2'd0,2'd1,2'd0,2'd0,0,0));
        drive(1, 6'h23, 0, 1); check("rst_in_mem", Z);
        drive(0, 6'h23, 0, 1); check("post_rst_fetch", FCH);
        drive(0, 6'h23, 0, 1); check("post_rst_decode", Z);

        // Randomized run against the reference model.
        drive(1, 0, 0, 1); check("rand_reset", Z);
        cyc = 0; rop = 6'h00; rfn = 6'h20;
        for (int n = 0; n < 3000; n++) begin
            rr  = ($urandom_range(0, 49) == 0);
            rmr = ($urandom_range(0, 9) < 7);
            if (cyc == 0) begin
                rop = op_pool[$urandom_range(0, 11)];
                rfn = (rop == 6'h00) ? fn_pool[$urandom_range(0, 3)] : 6'($urandom);
                if ($urandom_range(0, 15) == 0) rop = 6'($urandom);
            end
            drive(rr, rop, rfn, rmr);
            e = ref_out(rr, rop, rfn, cyc, rmr);
            check("random", e);
            cyc = ref_next(rr, rop, rfn, cyc, rmr, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
